// File: rtl/sr_pkg.sv
// Shared encodings and the per-cell next-state rule for the S/R latch bank.
package sr_pkg;

    // How a cell resolves simultaneous set and reset requests.
    localparam int MODE_HOLD    = 0;
    localparam int MODE_SET_DOM = 1;
    localparam int MODE_RST_DOM = 2;
    localparam int MODE_TOGGLE  = 3;

    // Next value of one storage cell, given the current value, both requests and the S&R mode.
    function automatic logic sr_next(input logic q, input logic s, input logic r, input int mode);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b00: nxt = q;
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            default: begin
                case (mode)
                    MODE_SET_DOM: nxt = 1'b1;
                    MODE_RST_DOM: nxt = 1'b0;
                    MODE_TOGGLE:  nxt = ~q;
                    default:      nxt = q;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One S/R channel: stored bit, its next-state logic and a sticky conflict flag.
module sr_cell
    import sr_pkg::*;
#(
    parameter int   MODE     = MODE_HOLD,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic load,
    input  logic load_val,
    input  logic clr_conflict,
    output logic q,
    output logic conflict,
    output logic hit
);

    logic q_q, q_d;
    logic conflict_q, conflict_d;

    // A conflict this cycle means both requests were seen while enabled.
    assign hit = en & s & r;

    // Next stored value: load wins over enabled S/R; otherwise hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = sr_next(q_q, s, r, MODE);
        end
    end

    // Sticky flag: clear first, then a fresh conflict in the same cycle sets it again.
    always_comb begin
        conflict_d = conflict_q;
        if (clr_conflict) begin
            conflict_d = 1'b0;
        end
        if (hit) begin
            conflict_d = 1'b1;
        end
    end

    // State registers with asynchronous reset to the configured initial value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= INIT_BIT;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign conflict = conflict_q;

endmodule

// File: rtl/sr_latch_bank.sv
// Clocked bank of WIDTH S/R storage cells with parallel load, per-channel sticky
// conflict flags and a saturating conflict-cycle counter.
// Optional feature: define SR_LATCH_BANK_SYNC_EN to pass s, r, load and clr_conflict
// through a 2-flop synchroniser before use (request-to-q latency becomes 3 cycles).
module sr_latch_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               MODE  = MODE_HOLD,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] s_use, r_use;
    logic             load_use, clr_use;
    logic [WIDTH-1:0] hit;

`ifdef SR_LATCH_BANK_SYNC_EN
    logic [WIDTH-1:0] s_meta_q, s_sync_q, r_meta_q, r_sync_q;
    logic             load_meta_q, load_sync_q, clr_meta_q, clr_sync_q;

    // Two-stage synchroniser for the asynchronous request inputs, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta_q    <= '0;
            s_sync_q    <= '0;
            r_meta_q    <= '0;
            r_sync_q    <= '0;
            load_meta_q <= 1'b0;
            load_sync_q <= 1'b0;
            clr_meta_q  <= 1'b0;
            clr_sync_q  <= 1'b0;
        end else begin
            s_meta_q    <= s;
            s_sync_q    <= s_meta_q;
            r_meta_q    <= r;
            r_sync_q    <= r_meta_q;
            load_meta_q <= load;
            load_sync_q <= load_meta_q;
            clr_meta_q  <= clr_conflict;
            clr_sync_q  <= clr_meta_q;
        end
    end

    assign s_use    = s_sync_q;
    assign r_use    = r_sync_q;
    assign load_use = load_sync_q;
    assign clr_use  = clr_sync_q;
`else
    assign s_use    = s;
    assign r_use    = r;
    assign load_use = load;
    assign clr_use  = clr_conflict;
`endif

    // One cell per channel; each owns its bit of q and its conflict flag.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE     (MODE),
            .INIT_BIT (INIT[i])
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .s            (s_use[i]),
            .r            (r_use[i]),
            .load         (load_use),
            .load_val     (load_val[i]),
            .clr_conflict (clr_use),
            .q            (q[i]),
            .conflict     (conflict[i]),
            .hit          (hit[i])
        );
    end

    assign qn = ~q;

    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // Counter clears first, then counts a conflict cycle, sticking at all-ones.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (clr_use) begin
            conflict_cnt_d = '0;
        end
        if ((|hit) && (conflict_cnt_d != CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_d + 1'b1;
        end
    end

    // Conflict counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;

endmodule
